// File: rtl/aer_pkg.sv
// Shared types and constants for the address-event receiver.
package aer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } aer_state_t;

  localparam int EVENT_CNT_W = 16;
  localparam int PULSE_CNT_W = 8;

  // Smallest address width able to name n neuron lines.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aer_if.sv
// Four-phase address-event link: transmitter drives req/addr, receiver answers with ack.
interface aer_if #(
  parameter int ADDR_WIDTH = 3
);

  logic                  aer_req;
  logic [ADDR_WIDTH-1:0] aer_addr;
  logic                  aer_ack;

  modport master (output aer_req, output aer_addr, input aer_ack);
  modport slave  (input aer_req, input aer_addr, output aer_ack);

endinterface

// File: rtl/aer_sync.sv
// Generic two-flop synchronizer; only compiled when AER_RX_SYNC_EN is defined,
// which is the only build that instantiates it.
`ifdef AER_RX_SYNC_EN
module aer_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`endif

// File: rtl/aer_receiver.sv
// AER receiver: four-phase handshake, address decode and per-neuron spike stretching.
// Define AER_RX_SYNC_EN to pass aer_req through a two-flop synchronizer.
module aer_receiver
  import aer_pkg::*;
#(
  parameter int VECTOR_WIDTH = 5,
  parameter int ADDR_WIDTH   = 3,
  parameter int PULSE_LEN    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  aer_if.slave                    aer,
  output logic [VECTOR_WIDTH-1:0] spikes,
  output logic                    addr_err,
  output logic [EVENT_CNT_W-1:0]  event_cnt
);

  // One extra bit so VECTOR_WIDTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]    VEC_LIMIT  = (ADDR_WIDTH + 1)'(VECTOR_WIDTH);
  localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD = PULSE_CNT_W'(PULSE_LEN);

  logic       req_s;
  logic       accept;
  logic       in_range;
  aer_state_t state, state_next;
  logic [PULSE_CNT_W-1:0] pulse_cnt [VECTOR_WIDTH];

`ifdef AER_RX_SYNC_EN
  aer_sync #(.WIDTH(1)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (aer.aer_req),
    .q     (req_s)
  );
`else
  assign req_s = aer.aer_req;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: if (req_s) begin
        state_next = ACK;
        accept     = 1'b1;
      end
      ACK:  if (!req_s) state_next = IDLE;
    endcase
  end

  assign aer.aer_ack = (state == ACK);
  assign in_range    = {1'b0, aer.aer_addr} < VEC_LIMIT;

  // Address is only looked at on the accepting edge; later changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: these counters are plain flops, not RAM; clearing them keeps spikes low out of reset.
      for (int i = 0; i < VECTOR_WIDTH; i++) pulse_cnt[i] <= '0;
      addr_err  <= 1'b0;
      event_cnt <= '0;
    end else begin
      for (int i = 0; i < VECTOR_WIDTH; i++) begin
        if (accept && in_range && aer.aer_addr == ADDR_WIDTH'(i))
          pulse_cnt[i] <= PULSE_LOAD;
        else if (pulse_cnt[i] != '0)
          pulse_cnt[i] <= pulse_cnt[i] - 1'b1;
      end
      addr_err <= accept && !in_range;
      if (accept && in_range) event_cnt <= event_cnt + 1'b1;
    end
  end

  always_comb begin
    spikes = '0;
    for (int i = 0; i < VECTOR_WIDTH; i++) spikes[i] = (pulse_cnt[i] != '0);
  end

endmodule

// File: tb/tb_aer_receiver.sv
// Self-checking bench for aer_receiver: table-driven handshakes, a per-cycle spike model
// and a scoreboard of expected event counts checked when aer_ack rises.
module tb_aer_receiver;
  import aer_pkg::*;

  localparam int VW = 5;
  localparam int AW = 3;
  localparam int PL = 4;
`ifdef AER_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int NV = 8;

  typedef struct {
    int addr;
    int hold;
    bit wiggle;
  } vec_t;

  typedef struct {
    logic [EVENT_CNT_W-1:0] cnt;
    logic                   err;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [VW-1:0]          spikes;
  logic                   addr_err;
  logic [EVENT_CNT_W-1:0] event_cnt;

  aer_if #(.ADDR_WIDTH(AW)) bus ();

  aer_receiver #(
    .VECTOR_WIDTH (VW),
    .ADDR_WIDTH   (AW),
    .PULSE_LEN    (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .aer       (bus),
    .spikes    (spikes),
    .addr_err  (addr_err),
    .event_cnt (event_cnt)
  );

  always #5 clk = ~clk;

  int                     n_tests = 0;
  int                     n_fail  = 0;
  int                     ref_cnt [VW];
  logic [EVENT_CNT_W-1:0] ref_events = '0;
  exp_t                   sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] ref_spikes();
    logic [VW-1:0] v = '0;
    for (int i = 0; i < VW; i++) v[i] = (ref_cnt[i] != 0);
    return v;
  endfunction

  // Advance one cycle; the reference loads addr on the edge just passed when load is set.
  task automatic tick(input bit load, input int addr);
    @(negedge clk);
    if (!reset) begin
      for (int i = 0; i < VW; i++) ref_cnt[i] = 0;
      ref_events = '0;
    end else begin
      for (int i = 0; i < VW; i++) if (ref_cnt[i] > 0) ref_cnt[i]--;
      if (load && addr < VW) ref_cnt[addr] = PL;
    end
    check("spikes", spikes, ref_spikes());
    check("addr_err", addr_err, reset && load && addr >= VW);
  endtask

  // aer_req is already high; expect ack LAT+1 edges later and the event accounted for.
  task automatic accept_wait(input int addr);
    int   c = 0;
    exp_t e;
    if (addr < VW) ref_events++;
    sb.push_back('{cnt: ref_events, err: (addr >= VW)});
    while (bus.aer_ack !== 1'b1 && c < 12) begin
      c++;
      tick(c == LAT + 1, addr);
    end
    check("ack_rise_latency", c, LAT + 1);
    e = sb.pop_front();
    check("event_cnt", event_cnt, e.cnt);
    check("addr_err_at_ack", addr_err, e.err);
  endtask

  task automatic release_wait(input int hold, input bit wiggle);
    int c = 0;
    for (int h = 0; h < hold; h++) begin
      if (wiggle) bus.aer_addr = bus.aer_addr + 1'b1;
      tick(1'b0, 0);
      check("ack_hold", bus.aer_ack, 1'b1);
    end
    bus.aer_req = 1'b0;
    while (bus.aer_ack !== 1'b0 && c < 12) begin
      c++;
      tick(1'b0, 0);
    end
    check("ack_fall_latency", c, LAT + 1);
  endtask

  initial begin
    vec_t vecs [NV];
    vecs[0] = '{addr: 2, hold: 5, wiggle: 1'b0};  // single event, pulse ends while req held
    vecs[1] = '{addr: 1, hold: 0, wiggle: 1'b0};  // retrigger pair on neuron 1
    vecs[2] = '{addr: 1, hold: 0, wiggle: 1'b0};
    vecs[3] = '{addr: 0, hold: 0, wiggle: 1'b0};  // overlapping pulses on 0 and 4
    vecs[4] = '{addr: 4, hold: 0, wiggle: 1'b0};
    vecs[5] = '{addr: 6, hold: 1, wiggle: 1'b0};  // out of range
    vecs[6] = '{addr: 7, hold: 0, wiggle: 1'b0};
    vecs[7] = '{addr: 3, hold: 2, wiggle: 1'b1};  // address changes during ACK are ignored

    reset        = 1'b0;
    bus.aer_req  = 1'b1;
    bus.aer_addr = AW'(3);
    repeat (3) begin
      tick(1'b0, 0);
      check("ack_in_reset", bus.aer_ack, 1'b0);
      check("event_cnt_in_reset", event_cnt, 16'h0);
    end
    reset = 1'b1;
    accept_wait(3);
    release_wait(0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      bus.aer_addr = AW'(vecs[i].addr);
      bus.aer_req  = 1'b1;
      accept_wait(vecs[i].addr);
      release_wait(vecs[i].hold, vecs[i].wiggle);
    end
    repeat (PL + 2) tick(1'b0, 0);
    check("event_cnt_after_table", event_cnt, 16'd7);

    // Reset while in ACK with req still high: ack drops, then the held req is a new event.
    bus.aer_addr = AW'(1);
    bus.aer_req  = 1'b1;
    accept_wait(1);
    reset = 1'b0;
    tick(1'b0, 0);
    check("ack_mid_reset", bus.aer_ack, 1'b0);
    check("event_cnt_mid_reset", event_cnt, 16'h0);
    reset = 1'b1;
    accept_wait(1);
    release_wait(0, 1'b0);
    repeat (PL + 2) tick(1'b0, 0);
    check("spikes_idle", spikes, '0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
